// File: rtl/draw_sched_pkg.sv
// Shared types and defaults for the sprite draw scheduler.
package draw_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAW  = 3'd2,
    ERASE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int DEF_COLOUR_W   = 3;
  localparam int SPRITE_PIXELS  = 16;
  localparam int DEF_FRAME_DIV  = 833334;
  localparam int DEF_WDOG_LIMIT = 2 * SPRITE_PIXELS;

endpackage

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [PW-1:0]      idx_o,
  output logic               any_req_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Walk the request vector starting at the pointer; the first hit wins
  always_comb begin
    pick_o    = '0;
    idx_o     = '0;
    any_req_o = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      cand = sum[PW-1:0];
      if (!any_req_o && req_i[cand]) begin
        pick_o[cand] = 1'b1;
        idx_o        = cand;
        any_req_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin sequencer sharing one 4x4 sprite draw datapath between
// NUM_REQ clients, plus the free-running frame-rate strobe.
// Optional build macro: DRAW_SCHED_WATCHDOG_EN (aborts a stuck draw/erase).
//
// state | meaning
// IDLE  | no service; arbitrate pending requests
// LOAD  | grant shown, colour load strobe to datapath
// DRAW  | draw_enable high until draw_complete
// ERASE | erase_enable high until draw_complete
// DONE  | done pulse to serviced client, advance RR pointer
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int COLOUR_W   = DEF_COLOUR_W,
  parameter  int FRAME_DIV  = DEF_FRAME_DIV,
  parameter  int WDOG_LIMIT = DEF_WDOG_LIMIT,
  localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_erase,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  input  logic                         draw_complete,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [COLOUR_W-1:0]          colour_in,
  output logic                         ld_colour,
  output logic                         draw_enable,
  output logic                         erase_enable,
  output logic                         busy,
  output logic                         frame_tick,
  output logic                         wdog_err
);

  localparam int            FW         = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);

  state_e              state_q, state_d;
  logic [PW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                erase_op_q, erase_op_d;
  logic [FW-1:0]       frame_q;

  logic [NUM_REQ-1:0]  arb_pick;
  logic [PW-1:0]       arb_idx;
  logic                arb_any;
  logic [COLOUR_W-1:0] sel_colour;
  logic                sel_erase;
  logic                wdog_expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .pick_o    (arb_pick),
    .idx_o     (arb_idx),
    .any_req_o (arb_any)
  );

  // Colour and op of the client the arbiter is currently picking
  always_comb begin
    sel_colour = '0;
    sel_erase  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_pick[i]) begin
        sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
        sel_erase  = req_erase[i];
      end
    end
  end

  // State, latched request and RR pointer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      colour_q   <= '0;
      erase_op_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ptr_q      <= ptr_d;
      colour_q   <= colour_d;
      erase_op_q <= erase_op_d;
    end
  end

  // Next-state logic and datapath control decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    colour_d     = colour_q;
    erase_op_d   = erase_op_q;
    grant        = '0;
    done         = '0;
    ld_colour    = 1'b0;
    draw_enable  = 1'b0;
    erase_enable = 1'b0;
    busy         = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (arb_any) begin
          idx_d      = arb_idx;
          colour_d   = sel_colour;
          erase_op_d = sel_erase;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        grant[idx_q] = 1'b1;
        ld_colour    = 1'b1;
        state_d      = erase_op_q ? ERASE : DRAW;
      end
      DRAW: begin
        grant[idx_q] = 1'b1;
        draw_enable  = 1'b1;
        if (draw_complete || wdog_expired) state_d = DONE;
      end
      ERASE: begin
        grant[idx_q] = 1'b1;
        erase_enable = 1'b1;
        if (draw_complete || wdog_expired) state_d = DONE;
      end
      DONE: begin
        grant[idx_q] = 1'b1;
        done[idx_q]  = 1'b1;
        ptr_d        = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign colour_in = colour_q;

  // Free-running frame divider, independent of the FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_q <= '0;
    end else if (frame_q == FRAME_LAST) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_q + 1'b1;
    end
  end

  assign frame_tick = (frame_q == FRAME_LAST);

`ifdef DRAW_SCHED_WATCHDOG_EN
  localparam int WW = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;

  logic [WW-1:0] wdog_q;
  logic          wdog_err_q;
  logic          in_op;

  assign in_op        = (state_q == DRAW) || (state_q == ERASE);
  assign wdog_expired = (wdog_q == '0);
  assign wdog_err     = wdog_err_q;

  // Down-counter armed in LOAD; reaching zero in DRAW/ERASE forces DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        wdog_q <= WW'(WDOG_LIMIT - 1);
      end else if (in_op && !wdog_expired) begin
        wdog_q <= wdog_q - 1'b1;
      end
      if (in_op && wdog_expired && !draw_complete) begin
        wdog_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog_limit;

  assign unused_wdog_limit = (WDOG_LIMIT != 0);
  assign wdog_expired      = 1'b0;
  assign wdog_err          = 1'b0;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  localparam int NR   = 4;
  localparam int CW   = 3;
  localparam int FDIV = 10;
  localparam int WDL  = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req, req_erase;
  logic [NR*CW-1:0]  req_colour;
  logic              draw_complete;
  logic [NR-1:0]     grant, done;
  logic [CW-1:0]     colour_in;
  logic              ld_colour, draw_enable, erase_enable, busy, frame_tick, wdog_err;

  draw_scheduler #(
    .NUM_REQ(NR), .COLOUR_W(CW), .FRAME_DIV(FDIV), .WDOG_LIMIT(WDL)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_erase(req_erase),
    .req_colour(req_colour), .draw_complete(draw_complete),
    .grant(grant), .done(done), .colour_in(colour_in), .ld_colour(ld_colour),
    .draw_enable(draw_enable), .erase_enable(erase_enable), .busy(busy),
    .frame_tick(frame_tick), .wdog_err(wdog_err)
  );

  always #5 clock = ~clock;

  // Stand-in for the datapath pixel counter
  logic [3:0] pix_q;
  logic       dp_stall;
  always @(posedge clock) begin
    if (reset) pix_q <= 4'd0;
    else if (draw_enable || erase_enable) pix_q <= pix_q + 4'd1;
  end
  assign draw_complete = !dp_stall && (pix_q == 4'd15);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: a service sampled at t=0 shows
  // LOAD at t=1, enable at t=2..17, done at t=18, idle again after.
  bit         model_on = 0;
  bit         m_act = 0;
  int         m_t = 0, m_idx = 0, m_ptr = 0, m_cyc = 0;
  logic [2:0] m_col = '0;
  bit         m_er = 0;

  task automatic model_step();
    if (reset) begin
      m_act = 0; m_ptr = 0; m_col = '0; m_cyc = 0; m_idx = 0;
    end else begin
      m_cyc++;
      if (m_act) begin
        if (m_t == 18) begin
          m_act = 0;
          m_ptr = (m_idx + 1) % NR;
        end else m_t++;
      end else if (req != '0) begin
        for (int k = 0; k < NR; k++) begin
          if (req[(m_ptr + k) % NR]) begin
            m_idx = (m_ptr + k) % NR;
            break;
          end
        end
        m_act = 1; m_t = 1;
        m_col = req_colour[m_idx*CW +: CW];
        m_er  = req_erase[m_idx];
      end
    end
  endtask

  function automatic logic [16:0] outs();
    return {grant, done, colour_in, ld_colour, draw_enable, erase_enable, busy, frame_tick, wdog_err};
  endfunction

  function automatic logic [16:0] model_exp();
    logic [3:0] g, d;
    logic ld, de, ee, bz, ft;
    g = '0; d = '0; ld = 0; de = 0; ee = 0; bz = 0;
    ft = ((m_cyc % FDIV) == FDIV - 1);
    if (m_act) begin
      bz = 1;
      g  = 4'b0001 << m_idx;
      if (m_t == 1) ld = 1;
      else if (m_t <= 17) begin
        if (m_er) ee = 1; else de = 1;
      end else d = g;
    end
    return {g, d, m_col, ld, de, ee, bz, ft, 1'b0};
  endfunction

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    if (model_on) chk("model", 32'(outs()), 32'(model_exp()));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] rq;
    logic [3:0] er;
    int         exp_idx;
    logic [2:0] exp_col;
    bit         exp_erase;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int lat, n_on, n_off;
    req = v.rq; req_erase = v.er;
    step();
    chk("vec_ld_grant", 32'({ld_colour, grant}), 32'({1'b1, 4'b0001 << v.exp_idx}));
    chk("vec_colour", 32'(colour_in), 32'(v.exp_col));
    lat = 1; n_on = 0; n_off = 0;
    while (done == '0 && lat < 60) begin
      step();
      lat++;
      if (v.exp_erase ? erase_enable : draw_enable) n_on++;
      if (v.exp_erase ? draw_enable : erase_enable) n_off++;
    end
    chk("vec_latency", 32'(lat), 32'd18);
    chk("vec_done", 32'(done), 32'(4'b0001 << v.exp_idx));
    chk("vec_en_cycles", 32'(n_on), 32'd16);
    chk("vec_other_en", 32'(n_off), 32'd0);
    chk("vec_colour_hold", 32'(colour_in), 32'(v.exp_col));
    req = '0;
    step();
    chk("vec_idle", 32'(busy), 32'd0);
  endtask

  task automatic drain();
    req = '0;
    for (int k = 0; k < 40 && busy; k++) step();
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int n, n_ld, tmask;
    int ld_idx[5];
    int ld_cyc[5];

    reset = 1'b1; req = '0; req_erase = '0; req_colour = '0; dp_stall = 1'b0;

    model_on = 1;
    do_reset();
    chk("reset_state", 32'(outs()), 32'd0);

    // client colours: c3=111 c2=101 c1=110 c0=011
    req_colour = 12'b111_101_110_011;
    vecs[0] = '{4'b0010, 4'b0000, 1, 3'b110, 1'b0};
    vecs[1] = '{4'b0100, 4'b0100, 2, 3'b101, 1'b1};
    vecs[2] = '{4'b0011, 4'b0000, 0, 3'b011, 1'b0};
    vecs[3] = '{4'b1001, 4'b1000, 3, 3'b111, 1'b1};
    vecs[4] = '{4'b1001, 4'b0000, 0, 3'b011, 1'b0};
    vecs[5] = '{4'b1110, 4'b0010, 1, 3'b110, 1'b1};
    vecs[6] = '{4'b0001, 4'b0001, 0, 3'b011, 1'b1};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // round robin with every client requesting
    do_reset();
    req = 4'hF; req_erase = '0;
    n_ld = 0;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (ld_colour && n_ld < 5) begin
        ld_cyc[n_ld] = c;
        ld_idx[n_ld] = 0;
        for (int b = 0; b < NR; b++) if (grant[b]) ld_idx[n_ld] = b;
        n_ld++;
      end
    end
    chk("rr_count", 32'(n_ld), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", 32'(ld_idx[i]), 32'(i % NR));
      chk("rr_spacing", 32'(ld_cyc[i]), 32'(1 + 19 * i));
    end
    drain();

    // reset in the 8th draw cycle; pointer must restart from 0
    do_reset();
    run_vec('{4'b0100, 4'b0000, 2, 3'b101, 1'b0});
    req = 4'b1010; req_erase = '0;
    step();
    chk("rst_pre_grant", 32'(grant), 32'(4'b1000));
    n = 0;
    for (int k = 0; k < 30 && n < 8; k++) begin
      step();
      if (draw_enable) n++;
    end
    chk("rst_pre_cycles", 32'(n), 32'd8);
    reset = 1'b1;
    step();
    chk("rst_mid_outs", 32'(outs()), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_reserve_grant", 32'({ld_colour, grant}), 32'({1'b1, 4'b0010}));
    for (int k = 0; k < 30 && done == '0; k++) step();
    chk("rst_reserve_done", 32'(done), 32'(4'b0010));
    drain();

    // frame tick positions while the FSM is busy
    do_reset();
    req = 4'hF;
    tmask = 0;
    for (int c = 0; c < 32; c++) begin
      if (frame_tick) tmask |= (1 << c);
      step();
    end
    chk("frame_ticks", 32'(tmask), 32'((1 << 9) | (1 << 19) | (1 << 29)));
    drain();

    // stuck datapath
    model_on = 0;
    do_reset();
    dp_stall = 1'b1;
    req = 4'b0001; req_erase = '0;
    step();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!draw_enable) break;
      n++;
    end
`ifdef DRAW_SCHED_WATCHDOG_EN
    chk("wdog_en_cycles", 32'(n), 32'(WDL));
    chk("wdog_done", 32'(done), 32'(4'b0001));
    chk("wdog_err_set", 32'(wdog_err), 32'd1);
    req = '0;
    repeat (5) step();
    chk("wdog_err_sticky", 32'(wdog_err), 32'd1);
    chk("wdog_idle", 32'(busy), 32'd0);
`else
    chk("nowdog_en_held", 32'(n), 32'd40);
    chk("nowdog_err", 32'(wdog_err), 32'd0);
`endif
    dp_stall = 1'b0;
    req = '0;
    do_reset();
    model_on = 1;

    // random traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 5) == 0) req_erase = 4'($urandom);
      if ($urandom_range(0, 5) == 0) req_colour = 12'($urandom);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
